// File: rtl/audio_pkg.sv
// Register map and field positions shared by the audio sample FIFO and its bench-facing docs.
package audio_pkg;

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_STATUS   = 2'd1,
        REG_CTRL     = 2'd2,
        REG_UNDERRUN = 2'd3
    } reg_off_e;

    localparam int ST_EMPTY    = 16;
    localparam int ST_FULL     = 17;
    localparam int ST_OVERFLOW = 18;
    localparam int ST_IRQ      = 19;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, RAM with registered show-ahead read: rdata always holds the head entry.
// Push is dropped when full (judged before any same-cycle pop); pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_next = flush ? '0 : rd_ptr + AW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The RAM reads old data on a same-address write, so forward the
    // incoming word when it lands exactly where the next head will be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (push_ok && (wr_ptr == rd_next)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[rd_next];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// CPU-to-DAC stereo sample buffer on the iomem bus; one pair popped per DACLRC rising edge, outputs 3 clk after the pin.
// Bus acks in one cycle, pushes to a full FIFO are dropped (sticky overflow); optional low-water irq under FIFO_IRQ_EN.
module audio_sample_fifo #(
    parameter int         BITSIZE   = 16,
    parameter int         FIFO_AW   = 8,
    parameter logic [7:0] BASE_PAGE = 8'h06,
    parameter int         LOW_WATER = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    input  logic               lrclk,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               irq
);

    import audio_pkg::*;

    localparam int WIDTH = 2 * BITSIZE;

    logic             sel;
    logic             is_wr;
    logic             is_rd;
    reg_off_e         reg_off;
    logic             data_push;
    logic             ctrl_wr;
    logic             flush;
    logic             und_clr;

    logic             enable;
    logic             overflow;
    logic [15:0]      underrun;

    logic [1:0]       lrclk_sync;
    logic             lrclk_prev;
    logic             frame_tick;
    logic             frame_pop;

    logic [WIDTH-1:0] fifo_wdata;
    logic [WIDTH-1:0] fifo_rdata;
    logic [FIFO_AW:0] fifo_level;
    logic             fifo_empty;
    logic             fifo_full;

    logic [31:0]      status_word;
    logic [31:0]      rd_val;
    logic             unused_addr;

    assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_PAGE);
    assign is_wr     = sel && (iomem_wstrb != 4'h0);
    assign is_rd     = sel && (iomem_wstrb == 4'h0);
    assign reg_off   = reg_off_e'(iomem_addr[3:2]);
    assign data_push = is_wr && (reg_off == REG_DATA) && (iomem_wstrb == 4'hF);
    assign ctrl_wr   = is_wr && (reg_off == REG_CTRL);
    assign flush     = ctrl_wr && iomem_wdata[CTRL_FLUSH];
    assign und_clr   = is_wr && (reg_off == REG_UNDERRUN);

    assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

    // Packed as {right, left} so the FIFO word splits directly onto the outputs.
    assign fifo_wdata = {iomem_wdata[16 +: BITSIZE], iomem_wdata[0 +: BITSIZE]};

    sync_fifo #(
        .WIDTH (WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_push),
        .pop   (frame_pop),
        .flush (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign frame_tick = lrclk_sync[1] && !lrclk_prev;
    assign frame_pop  = frame_tick && enable && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrclk_sync <= '0;
            lrclk_prev <= 1'b0;
        end else begin
            lrclk_sync <= {lrclk_sync[0], lrclk};
            lrclk_prev <= lrclk_sync[1];
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[FIFO_AW:0]     = fifo_level;
        status_word[ST_EMPTY]      = fifo_empty;
        status_word[ST_FULL]       = fifo_full;
        status_word[ST_OVERFLOW]   = overflow;
        status_word[ST_IRQ]        = irq;
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            REG_STATUS:   rd_val = status_word;
            REG_CTRL:     rd_val[CTRL_EN] = enable;
            REG_UNDERRUN: rd_val[15:0] = underrun;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= is_rd ? rd_val : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= iomem_wdata[CTRL_EN];
            end
            if (data_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && iomem_wdata[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= '0;
        end else if (und_clr) begin
            underrun <= '0;
        end else if (frame_tick && enable && fifo_empty && (underrun != UNDERRUN_MAX)) begin
            underrun <= underrun + 16'd1;
        end
    end

    // On an underrun the previous pair is replayed rather than muted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_chan  <= '0;
            right_chan <= '0;
        end else if (frame_tick) begin
            if (!enable) begin
                left_chan  <= '0;
                right_chan <= '0;
            end else if (!fifo_empty) begin
                left_chan  <= fifo_rdata[0 +: BITSIZE];
                right_chan <= fifo_rdata[BITSIZE +: BITSIZE];
            end
        end
    end

`ifdef FIFO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= enable && (fifo_level < (FIFO_AW+1)'(LOW_WATER));
        end
    end
`else
    logic unused_low_water;
    assign unused_low_water = (LOW_WATER != 0);
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: queue-based reference model, randomized bus and frame traffic.
module tb_audio_sample_fifo;

    localparam int DEPTH     = 256;
    localparam int LOW_WATER = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        lrclk = 1'b0;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        irq;

    always #5 clk = ~clk;

    audio_sample_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .lrclk       (lrclk),
        .left_chan   (left_chan),
        .right_chan  (right_chan),
        .irq         (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit          bus_rd_q[$];
    logic [31:0] bus_exp_q[$];
    logic [1:0]  bus_off_q[$];
    logic [31:0] frm_q[$];
    logic        ready_prev = 1'b0;

    logic [31:0] m_q[$];
    bit          m_en;
    bit          m_ovf;
    logic [15:0] m_und;
    logic [15:0] m_l;
    logic [15:0] m_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic string reg_name(input logic [1:0] off);
        case (off)
            2'd0:    return "read_data";
            2'd1:    return "read_status";
            2'd2:    return "read_ctrl";
            default: return "read_underrun";
        endcase
    endfunction

    function automatic bit m_irq();
`ifdef FIFO_IRQ_EN
        return m_en && (m_q.size() < LOW_WATER);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] w;
        w      = '0;
        w[8:0] = 9'(m_q.size());
        w[16]  = (m_q.size() == 0);
        w[17]  = (m_q.size() == DEPTH);
        w[18]  = m_ovf;
        w[19]  = m_irq();
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_en  = 1'b0;
        m_ovf = 1'b0;
        m_und = '0;
        m_l   = '0;
        m_r   = '0;
    endtask

    task automatic model_frame();
        logic [31:0] w;
        if (!m_en) begin
            m_l = '0;
            m_r = '0;
        end else if (m_q.size() > 0) begin
            w   = m_q.pop_front();
            m_l = w[15:0];
            m_r = w[31:16];
        end else if (m_und != 16'hFFFF) begin
            m_und = m_und + 16'd1;
        end
        frm_q.push_back({m_r, m_l});
    endtask

    task automatic model_write(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] data);
        case (off)
            2'd0: if (strb == 4'hF) begin
                if (m_q.size() == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(data);
            end
            2'd2: begin
                m_en = data[0];
                if (data[1]) m_q.delete();
                if (data[2]) m_ovf = 1'b0;
            end
            2'd3: m_und = '0;
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the ack.
    task automatic bus_op(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] exp;
        exp = '0;
        if (addr[31:24] == 8'h06) begin
            if (strb == 4'h0) begin
                case (addr[3:2])
                    2'd1:    exp = m_status();
                    2'd2:    exp = {31'd0, m_en};
                    2'd3:    exp = {16'd0, m_und};
                    default: exp = '0;
                endcase
            end else begin
                model_write(addr[3:2], strb, data);
            end
            bus_rd_q.push_back(strb == 4'h0);
            bus_exp_q.push_back(exp);
            bus_off_q.push_back(addr[3:2]);
        end
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] off);
        logic [31:0] a;
        a = {8'h06, 20'($urandom), off, 2'($urandom)};
        return a;
    endfunction

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        bus_op(reg_addr(off), 4'hF, data);
    endtask

    task automatic rd(input logic [1:0] off);
        bus_op(reg_addr(off), 4'h0, 32'd0);
    endtask

    task automatic frame();
        model_frame();
        lrclk = 1'b1;
        repeat (8) @(posedge clk);
        #1 lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (iomem_ready) begin
            check("ready_one_cycle", {31'd0, ready_prev}, 32'd0);
            if (bus_rd_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_ready: ready=1 with no access issued");
            end else begin
                bit          r;
                logic [31:0] e;
                logic [1:0]  o;
                r = bus_rd_q.pop_front();
                e = bus_exp_q.pop_front();
                o = bus_off_q.pop_front();
                if (r) check(reg_name(o), iomem_rdata, e);
            end
        end
        ready_prev <= iomem_ready;
    end

    always @(posedge lrclk) begin
        logic [31:0] e;
        repeat (3) @(posedge clk);
        #1;
        if (frm_q.size() == 0) begin
            n_chk++;
            $display("FAIL frame_unexpected: lrclk edge with no queued expectation");
        end else begin
            e = frm_q.pop_front();
            check("frame_left",  {16'd0, left_chan},  {16'd0, e[15:0]});
            check("frame_right", {16'd0, right_chan}, {16'd0, e[31:16]});
            repeat (3) @(posedge clk);
            #1;
            check("frame_left_hold",  {16'd0, left_chan},  {16'd0, e[15:0]});
            check("frame_right_hold", {16'd0, right_chan}, {16'd0, e[31:16]});
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_left",  {16'd0, left_chan},  32'd0);
        check("reset_right", {16'd0, right_chan}, 32'd0);
        check("reset_ready", {31'd0, iomem_ready}, 32'd0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_irq",   {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a frame with 10 pairs queued.
        rd(2'd1);
        for (int i = 0; i < 11; i++) wr(2'd0, $urandom);
        wr(2'd2, 32'h1);
        frame();
        check("pre_reset_level", {23'd0, 9'(m_q.size())}, 32'd10);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midreset_left",  {16'd0, left_chan},  32'd0);
        check("midreset_right", {16'd0, right_chan}, 32'd0);
        check("midreset_irq",   {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        rd(2'd1);
        rd(2'd3);
        rd(2'd2);

        // Two pairs, three frames: third frame underruns and holds.
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h7FFF8000);
        wr(2'd0, 32'h00010002);
        frame();
        frame();
        frame();
        check("hold_left_const", {16'd0, left_chan}, 32'h0002);
        check("hold_right_const", {16'd0, right_chan}, 32'h0001);
        rd(2'd3);
        wr(2'd3, 32'h0);

        // Overfill with enable off, then drain everything.
        wr(2'd2, 32'h2);
        for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, {16'(i + 16'h100), 16'(i)});
        rd(2'd1);
        wr(2'd2, 32'h1);
        for (int i = 0; i < DEPTH + 1; i++) frame();
        check("drain_last_left", {16'd0, left_chan}, 32'h00FF);
        rd(2'd1);
        wr(2'd2, 32'h5);
        rd(2'd1);
        wr(2'd3, 32'h0);

        // Push lands on the same edge as the frame pop.
        for (int i = 0; i < 5; i++) wr(2'd0, $urandom);
        model_frame();
        lrclk = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr(2'd0, $urandom);
        repeat (4) @(posedge clk);
        #1 lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rd(2'd1);
        for (int i = 0; i < 6; i++) frame();

        // Flush leaves the outputs alone; the next enabled frame underruns.
        wr(2'd0, 32'hA5A55A5A);
        frame();
        for (int i = 0; i < 100; i++) wr(2'd0, $urandom);
        rd(2'd1);
        wr(2'd2, 32'h2);
        check("flush_left",  {16'd0, left_chan},  {16'd0, m_l});
        check("flush_right", {16'd0, right_chan}, {16'd0, m_r});
        rd(2'd1);
        wr(2'd2, 32'h1);
        frame();
        rd(2'd3);

`ifdef FIFO_IRQ_EN
        wr(2'd2, 32'h3);
        for (int i = 0; i < LOW_WATER; i++) wr(2'd0, $urandom);
        check("irq_at_water", {31'd0, irq}, {31'd0, m_irq()});
        frame();
        check("irq_below_water", {31'd0, irq}, {31'd0, m_irq()});
        rd(2'd1);
        wr(2'd0, $urandom);
        check("irq_refilled", {31'd0, irq}, {31'd0, m_irq()});
`endif

        // Random mix of traffic.
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0, 1, 2, 3: begin
                    if ($urandom_range(0, 4) == 0) bus_op(reg_addr(2'd0), 4'($urandom_range(1, 14)), d);
                    else wr(2'd0, d);
                end
                4: rd(2'($urandom));
                5: frame();
                6: begin
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    d[1] = ($urandom_range(0, 5) == 0);
                    wr(2'd2, d);
                end
                7: if (d[0]) wr(2'd3, d); else rd(2'd3);
                8: bus_op({8'($urandom_range(7, 255)), d[23:0]}, 4'($urandom), d);
                default: rd(2'd1);
            endcase
        end
        rd(2'd1);
        rd(2'd3);
        check("final_irq", {31'd0, irq}, {31'd0, m_irq()});

        repeat (20) @(posedge clk);
        #1;
        check("bus_queue_drained", 32'(bus_rd_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
